// File: rtl/gtfmac_vnc_bus_event_mux.sv
// N-channel bus change detector: changed values are held per channel, coalesced while
// waiting, and serialised round-robin onto one valid/ready output.
module gtfmac_vnc_bus_event_mux #(
    parameter int WIDTH = 8,
    parameter int NCH   = 4,
    parameter int CNT_W = 16,
    localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NCH*WIDTH-1:0] busin,
    input  logic [NCH-1:0]       chan_en,
    input  logic                 out_ready,
    input  logic                 cnt_clear,
    output logic                 out_valid,
    output logic [CH_W-1:0]      out_chan,
    output logic [WIDTH-1:0]     out_data,
    output logic [NCH-1:0]       pending,
    output logic [CNT_W-1:0]     coalesce_cnt
);

    logic [WIDTH-1:0] samp [NCH];
    logic [WIDTH-1:0] hold [NCH];
    logic [CH_W-1:0]  ptr;
    logic [NCH-1:0]   chg;
    logic [NCH-1:0]   pending_nxt;
    logic             slot_free;
    logic             found;
    logic             grant;
    logic [CH_W-1:0]  grant_idx;
    logic [CNT_W-1:0] cnt_nxt;

    assign slot_free = !out_valid || out_ready;
    assign grant     = slot_free && found;

    // Round-robin search: first pending channel after the last one granted, wrapping.
    always_comb begin : grant_search
        int cand;
        found     = 1'b0;
        grant_idx = '0;
        cand      = 0;
        for (int k = 1; k <= NCH; k++) begin
            cand = int'(ptr) + k;
            if (cand >= NCH) begin
                cand = cand - NCH;
            end
            if (!found && pending[CH_W'(cand)]) begin
                found     = 1'b1;
                grant_idx = CH_W'(cand);
            end
        end
    end

    // A change on a channel still waiting (and not leaving this cycle) overwrites its
    // held value; every such overwrite bumps the counter, clear taking effect first.
    always_comb begin : change_detect
        int                n_inc;
        logic              taken;
        logic [CNT_W-1:0]  base;
        logic [CNT_W+6:0]  sum;
        n_inc       = 0;
        taken       = 1'b0;
        chg         = '0;
        pending_nxt = pending;
        for (int i = 0; i < NCH; i++) begin
            chg[i]         = chan_en[i] && (busin[i*WIDTH +: WIDTH] != samp[i]);
            taken          = grant && (grant_idx == CH_W'(i));
            pending_nxt[i] = chg[i] || (pending[i] && !taken);
            if (chg[i] && pending[i] && !taken) begin
                n_inc = n_inc + 1;
            end
        end
        base    = cnt_clear ? '0 : coalesce_cnt;
        sum     = (CNT_W+7)'(base) + (CNT_W+7)'(n_inc);
        cnt_nxt = (sum > (CNT_W+7)'({CNT_W{1'b1}})) ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    end

    // Sampling runs even for disabled channels so re-enabling never sees a stale value.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NCH; i++) begin
                samp[i] <= '0;
                hold[i] <= '0;
            end
            pending      <= '0;
            coalesce_cnt <= '0;
            ptr          <= CH_W'(NCH - 1);
            out_valid    <= 1'b0;
            out_chan     <= '0;
            out_data     <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                samp[i] <= busin[i*WIDTH +: WIDTH];
                if (chg[i]) begin
                    hold[i] <= busin[i*WIDTH +: WIDTH];
                end
            end
            pending      <= pending_nxt;
            coalesce_cnt <= cnt_nxt;
            if (slot_free) begin
                out_valid <= grant;
                if (grant) begin
                    out_chan <= grant_idx;
                    out_data <= hold[grant_idx];
                    ptr      <= grant_idx;
                end
            end
        end
    end

endmodule

// File: tb/tb_gtfmac_vnc_bus_event_mux.sv
// Scoreboard bench for gtfmac_vnc_bus_event_mux: expected beats are queued when
// stimulus is driven and compared as the DUT hands them over.
module tb_gtfmac_vnc_bus_event_mux;

    localparam int WIDTH = 8;
    localparam int NCH   = 4;
    localparam int CNT_W = 16;
    localparam int CH_W  = 2;

    typedef struct packed {
        logic [CH_W-1:0]  ch;
        logic [WIDTH-1:0] d;
    } beat_t;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic [NCH*WIDTH-1:0] busin = '0;
    logic [NCH-1:0]       chan_en = '1;
    logic                 out_ready = 1'b1;
    logic                 cnt_clear = 1'b0;
    logic                 out_valid;
    logic [CH_W-1:0]      out_chan;
    logic [WIDTH-1:0]     out_data;
    logic [NCH-1:0]       pending;
    logic [CNT_W-1:0]     coalesce_cnt;

    int    errors = 0;
    int    checks = 0;
    beat_t exp_q[$];
    beat_t mon_e;

    gtfmac_vnc_bus_event_mux #(.WIDTH(WIDTH), .NCH(NCH), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .busin        (busin),
        .chan_en      (chan_en),
        .out_ready    (out_ready),
        .cnt_clear    (cnt_clear),
        .out_valid    (out_valid),
        .out_chan     (out_chan),
        .out_data     (out_data),
        .pending      (pending),
        .coalesce_cnt (coalesce_cnt)
    );

    always #5 clk = ~clk;

    // Every accepted beat must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (reset && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL beat_unexpected: got ch%0d/0x%02h, expected no beat", out_chan, out_data);
            end else begin
                mon_e = exp_q.pop_front();
                if (out_chan !== mon_e.ch || out_data !== mon_e.d) begin
                    errors++;
                    $display("[TB] FAIL beat_order: got ch%0d/0x%02h, expected ch%0d/0x%02h",
                             out_chan, out_data, mon_e.ch, mon_e.d);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, expected $finish", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic at_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic next_edge();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_ch(input int ch, input logic [WIDTH-1:0] v);
        busin[ch*WIDTH +: WIDTH] = v;
    endtask

    task automatic push_exp(input int ch, input logic [WIDTH-1:0] v);
        beat_t b;
        b.ch = CH_W'(ch);
        b.d  = v;
        exp_q.push_back(b);
    endtask

    task automatic do_reset();
        at_edge();
        busin     = '0;
        chan_en   = '1;
        out_ready = 1'b1;
        cnt_clear = 1'b0;
        reset     = 1'b0;
        exp_q.delete();
        #3 reset = 1'b1;
    endtask

    task automatic test_reset();
        #1 reset = 1'b0;
        #2;
        checks++;
        if (out_valid !== 1'b0 || pending !== '0 || coalesce_cnt !== '0 || out_data !== '0) begin
            errors++;
            $display("[TB] FAIL reset_in_reset: got v=%b p=%b c=%0d d=%h, expected all 0",
                     out_valid, pending, coalesce_cnt, out_data);
        end
        #20 reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            next_edge();
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset_idle_valid: cycle %0d got %b, expected 0", i, out_valid);
            end
        end
        checks++;
        if (out_chan !== '0 || out_data !== '0 || pending !== '0 || coalesce_cnt !== '0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got ch=%0d d=%h p=%b c=%0d, expected all 0",
                     out_chan, out_data, pending, coalesce_cnt);
        end
    endtask

    task automatic test_single_change();
        at_edge();
        set_ch(2, 8'h5A);
        push_exp(2, 8'h5A);
        next_edge();
        checks++;
        if (out_valid !== 1'b0 || pending !== 4'b0100) begin
            errors++;
            $display("[TB] FAIL single_edge1: got v=%b p=%b, expected v=0 p=0100", out_valid, pending);
        end
        next_edge();
        checks++;
        if (out_valid !== 1'b1 || out_chan !== 2'd2 || out_data !== 8'h5A) begin
            errors++;
            $display("[TB] FAIL single_edge2: got v=%b ch%0d/0x%02h, expected v=1 ch2/0x5a",
                     out_valid, out_chan, out_data);
        end
        next_edge();
        checks++;
        if (out_valid !== 1'b0 || exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL single_once: got v=%b left=%0d, expected v=0 left=0", out_valid, exp_q.size());
        end
    endtask

    task automatic test_round_robin();
        logic [CH_W-1:0] order [3];
        order = '{2'd0, 2'd1, 2'd3};
        do_reset();
        at_edge();
        set_ch(0, 8'h10);
        set_ch(1, 8'h21);
        set_ch(3, 8'h43);
        push_exp(0, 8'h10);
        push_exp(1, 8'h21);
        push_exp(3, 8'h43);
        next_edge();
        checks++;
        if (pending !== 4'b1011) begin
            errors++;
            $display("[TB] FAIL rr_pending: got %b, expected 1011", pending);
        end
        for (int k = 0; k < 3; k++) begin
            next_edge();
            checks++;
            if (out_valid !== 1'b1 || out_chan !== order[k]) begin
                errors++;
                $display("[TB] FAIL rr_order: beat %0d got v=%b ch%0d, expected v=1 ch%0d",
                         k, out_valid, out_chan, order[k]);
            end
        end
        next_edge();
        at_edge();
        set_ch(0, 8'h11);
        set_ch(2, 8'h22);
        push_exp(0, 8'h11);
        push_exp(2, 8'h22);
        next_edge();
        next_edge();
        checks++;
        if (out_valid !== 1'b1 || out_chan !== 2'd0) begin
            errors++;
            $display("[TB] FAIL rr_wrap: got v=%b ch%0d, expected v=1 ch0", out_valid, out_chan);
        end
        next_edge();
        next_edge();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL rr_drain: got %0d beats outstanding, expected 0", exp_q.size());
        end
    endtask

    task automatic test_coalesce();
        do_reset();
        at_edge();
        out_ready = 1'b0;
        set_ch(0, 8'h77);
        push_exp(0, 8'h77);
        at_edge();
        set_ch(1, 8'h11);
        at_edge();
        set_ch(1, 8'h22);
        at_edge();
        set_ch(1, 8'h33);
        next_edge();
        checks++;
        if (coalesce_cnt !== 16'd2 || pending !== 4'b0010) begin
            errors++;
            $display("[TB] FAIL coalesce_cnt: got c=%0d p=%b, expected c=2 p=0010", coalesce_cnt, pending);
        end
        checks++;
        if (out_valid !== 1'b1 || out_chan !== 2'd0 || out_data !== 8'h77) begin
            errors++;
            $display("[TB] FAIL coalesce_hold: got v=%b ch%0d/0x%02h, expected v=1 ch0/0x77",
                     out_valid, out_chan, out_data);
        end
        at_edge();
        out_ready = 1'b1;
        push_exp(1, 8'h33);
        repeat (3) next_edge();
        checks++;
        if (out_valid !== 1'b0 || exp_q.size() != 0 || coalesce_cnt !== 16'd2) begin
            errors++;
            $display("[TB] FAIL coalesce_drain: got v=%b left=%0d c=%0d, expected v=0 left=0 c=2",
                     out_valid, exp_q.size(), coalesce_cnt);
        end
    endtask

    task automatic test_cnt_clear();
        at_edge();
        out_ready = 1'b0;
        set_ch(2, 8'h01);
        push_exp(2, 8'h01);
        at_edge();
        set_ch(3, 8'h05);
        at_edge();
        set_ch(3, 8'h06);
        cnt_clear = 1'b1;
        next_edge();
        checks++;
        if (coalesce_cnt !== 16'd1) begin
            errors++;
            $display("[TB] FAIL clear_with_inc: got %0d, expected 1", coalesce_cnt);
        end
        next_edge();
        checks++;
        if (coalesce_cnt !== 16'd0) begin
            errors++;
            $display("[TB] FAIL clear_plain: got %0d, expected 0", coalesce_cnt);
        end
        at_edge();
        cnt_clear = 1'b0;
        out_ready = 1'b1;
        push_exp(3, 8'h06);
        repeat (3) next_edge();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL clear_drain: got %0d beats outstanding, expected 0", exp_q.size());
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        at_edge();
        set_ch(1, 8'h44);
        push_exp(1, 8'h44);
        at_edge();
        set_ch(1, 8'h55);
        push_exp(1, 8'h55);
        next_edge();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h44 || pending[1] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL b2b_first: got v=%b d=0x%02h p1=%b, expected v=1 d=0x44 p1=1",
                     out_valid, out_data, pending[1]);
        end
        next_edge();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h55 || pending[1] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b2b_second: got v=%b d=0x%02h p1=%b, expected v=1 d=0x55 p1=0",
                     out_valid, out_data, pending[1]);
        end
        next_edge();
        checks++;
        if (out_valid !== 1'b0 || coalesce_cnt !== 16'd0 || exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL b2b_end: got v=%b c=%0d left=%0d, expected v=0 c=0 left=0",
                     out_valid, coalesce_cnt, exp_q.size());
        end
    endtask

    task automatic test_chan_disable();
        do_reset();
        at_edge();
        chan_en = 4'b0111;
        set_ch(3, 8'h99);
        at_edge();
        set_ch(3, 8'h98);
        at_edge();
        set_ch(3, 8'h97);
        repeat (2) next_edge();
        checks++;
        if (pending !== '0 || out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL disable_ignore: got p=%b v=%b, expected p=0000 v=0", pending, out_valid);
        end
        at_edge();
        chan_en = 4'b1111;
        repeat (3) next_edge();
        checks++;
        if (pending !== '0 || out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reenable_spurious: got p=%b v=%b, expected p=0000 v=0", pending, out_valid);
        end
        at_edge();
        out_ready = 1'b0;
        set_ch(0, 8'h31);
        push_exp(0, 8'h31);
        at_edge();
        set_ch(2, 8'h32);
        push_exp(2, 8'h32);
        at_edge();
        chan_en = 4'b1011;
        next_edge();
        checks++;
        if (pending[2] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL disable_keeps: got p2=%b, expected 1", pending[2]);
        end
        at_edge();
        out_ready = 1'b1;
        repeat (3) next_edge();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL disable_drain: got %0d beats outstanding, expected 0", exp_q.size());
        end
    endtask

    task automatic test_reset_midflight();
        at_edge();
        out_ready = 1'b0;
        chan_en   = '1;
        set_ch(1, 8'h66);
        next_edge();
        next_edge();
        checks++;
        if (out_valid !== 1'b1 || out_chan !== 2'd1) begin
            errors++;
            $display("[TB] FAIL mid_setup: got v=%b ch%0d, expected v=1 ch1", out_valid, out_chan);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_chan !== '0 || out_data !== '0 || pending !== '0 || coalesce_cnt !== '0) begin
            errors++;
            $display("[TB] FAIL mid_async_clear: got v=%b ch=%0d d=%h p=%b c=%0d, expected all 0",
                     out_valid, out_chan, out_data, pending, coalesce_cnt);
        end
        exp_q.delete();
        out_ready = 1'b1;
        push_exp(0, 8'h31);
        push_exp(1, 8'h66);
        push_exp(2, 8'h32);
        push_exp(3, 8'h97);
        @(posedge clk);
        #3 reset = 1'b1;
        repeat (7) next_edge();
        checks++;
        if (exp_q.size() != 0 || out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL post_reset_detect: got left=%0d v=%b, expected left=0 v=0", exp_q.size(), out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_single_change();
        test_round_robin();
        test_coalesce();
        test_cnt_clear();
        test_back_to_back();
        test_chan_disable();
        test_reset_midflight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
